dmx_tx: RTL



---
 rtl/dmx_pkg.sv | 35 +++
 rtl/dmx_tx_if.sv | 13 +
 rtl/dmx_dpram.sv | 36 +++
 rtl/dmx_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared DMX512 transmitter definitions: FSM states, slot count, CSR bit positions
// and timing-constant helpers derived from the system clock frequency.
package dmx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StMab,
        StStart,
        StData,
        StStop1,
        StStop2
    } dmx_state_e;

    localparam int unsigned SlotCount    = 513;
    localparam logic [9:0]  LastSlot     = 10'(SlotCount - 1);
    localparam int unsigned CtrlSelBit   = 9;
    localparam int unsigned EnableBit    = 0;
    localparam int unsigned CntWidth     = 14;
    localparam int unsigned CsrAddrWidth = 14;
    localparam int unsigned CsrDataWidth = 32;

    function automatic int unsigned bit_cycles(input int unsigned clk_freq);
        return clk_freq / 250000;
    endfunction

    function automatic int unsigned break_cycles(input int unsigned clk_freq);
        return clk_freq / 11364;
    endfunction

    function automatic int unsigned mab_cycles(input int unsigned clk_freq);
        return clk_freq / 125000;
    endfunction

endpackage

// File: rtl/dmx_tx_if.sv
// CSR bus bundle between the CPU side (master) and the DMX transmitter (slave).
interface dmx_tx_if;
    import dmx_pkg::*;

    logic [CsrAddrWidth-1:0] csr_a;
    logic                    csr_we;
    logic [CsrDataWidth-1:0] csr_di;
    logic [CsrDataWidth-1:0] csr_do;

    modport master (output csr_a, output csr_we, output csr_di, input csr_do);
    modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);

endinterface

// File: rtl/dmx_dpram.sv
// Simple dual-port RAM with registered read on both ports; a read and a write to
// the same address in one cycle return the old contents.
module dmx_dpram #(
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned DataWidth = 8
) (
    input  logic                 i_clk,
    input  logic [AddrWidth-1:0] i_a1,
    input  logic                 i_we1,
    input  logic [DataWidth-1:0] i_di1,
    output logic [DataWidth-1:0] o_do1,
    input  logic [AddrWidth-1:0] i_a2,
    input  logic                 i_we2,
    input  logic [DataWidth-1:0] i_di2,
    output logic [DataWidth-1:0] o_do2
);

    logic [DataWidth-1:0] r_mem [2**AddrWidth];
    logic [DataWidth-1:0] r_do1;
    logic [DataWidth-1:0] r_do2;

    always_ff @(posedge i_clk) begin
        if (i_we1) begin
            r_mem[i_a1] <= i_di1;
        end
        if (i_we2) begin
            r_mem[i_a2] <= i_di2;
        end
        r_do1 <= r_mem[i_a1];
        r_do2 <= r_mem[i_a2];
    end

    assign o_do1 = r_do1;
    assign o_do2 = r_do2;

endmodule

// File: rtl/dmx_tx.sv
// DMX512 transmitter: CSR-written 512-byte channel RAM streamed as continuous
// break / MAB / start-code / 512-slot frames on a registered line output.
module dmx_tx
    import dmx_pkg::*;
#(
    parameter logic [3:0]  csr_addr = 4'h0,
    parameter int unsigned clk_freq = 100000000
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    dmx_tx_if.slave  csr,
    output logic     tx
);

    localparam logic [CntWidth-1:0] BitReload   = CntWidth'(bit_cycles(clk_freq) - 1);
    localparam logic [CntWidth-1:0] BreakReload = CntWidth'(break_cycles(clk_freq) - 1);
    localparam logic [CntWidth-1:0] MabReload   = CntWidth'(mab_cycles(clk_freq) - 1);

    logic                w_sel;
    logic                w_is_ctrl;
    logic                w_ram_we;
    logic [7:0]          w_ram_do1;
    logic [7:0]          w_ram_rd;
    logic                w_unused_di;

    logic                r_enable;
    logic                r_rd_sel;
    logic                r_rd_ctrl;
    logic                r_rd_en;

    dmx_state_e          r_state, w_state_d;
    logic [CntWidth-1:0] r_cnt, w_cnt_d;
    logic [2:0]          r_bit, w_bit_d;
    logic [7:0]          r_shift, w_shift_d;
    logic [9:0]          r_slot, w_slot_d;
    logic                r_tx, w_tx_d;
    logic                w_cnt_zero;

    assign w_sel       = (csr.csr_a[13:10] == csr_addr);
    assign w_is_ctrl   = csr.csr_a[CtrlSelBit];
    assign w_ram_we    = w_sel & ~w_is_ctrl & csr.csr_we;
    assign w_unused_di = ^csr.csr_di[31:8];

    // Port 2 address is the current slot index, i.e. the RAM byte of the next slot.
    dmx_dpram #(
        .AddrWidth(9),
        .DataWidth(8)
    ) u_ram (
        .i_clk (sys_clk),
        .i_a1  (csr.csr_a[8:0]),
        .i_we1 (w_ram_we),
        .i_di1 (csr.csr_di[7:0]),
        .o_do1 (w_ram_do1),
        .i_a2  (r_slot[8:0]),
        .i_we2 (1'b0),
        .i_di2 (8'h00),
        .o_do2 (w_ram_rd)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_enable  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_rd_ctrl <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            if (w_sel && w_is_ctrl && csr.csr_we) begin
                r_enable <= csr.csr_di[EnableBit];
            end
            r_rd_sel  <= w_sel;
            r_rd_ctrl <= w_is_ctrl;
            r_rd_en   <= r_enable;
        end
    end

    always_comb begin
        csr.csr_do = '0;
        if (r_rd_sel) begin
            csr.csr_do = r_rd_ctrl ? {31'h0, r_rd_en} : {24'h0, w_ram_do1};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_slot  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_slot  <= w_slot_d;
            r_tx    <= w_tx_d;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = w_cnt_zero ? r_cnt : r_cnt - CntWidth'(1);
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_slot_d  = r_slot;
        w_tx_d    = 1'b1;
        case (r_state)
            StIdle: begin
                if (r_enable) begin
                    w_state_d = StBreak;
                    w_cnt_d   = BreakReload;
                end
            end
            StBreak: begin
                w_tx_d = 1'b0;
                if (w_cnt_zero) begin
                    w_state_d = StMab;
                    w_cnt_d   = MabReload;
                    w_slot_d  = '0;
                end
            end
            StMab: begin
                if (w_cnt_zero) begin
                    w_state_d = StStart;
                    w_cnt_d   = BitReload;
                    w_shift_d = 8'h00;
                end
            end
            StStart: begin
                w_tx_d = 1'b0;
                if (w_cnt_zero) begin
                    w_state_d = StData;
                    w_cnt_d   = BitReload;
                    w_bit_d   = '0;
                end
            end
            StData: begin
                w_tx_d = r_shift[0];
                if (w_cnt_zero) begin
                    w_cnt_d   = BitReload;
                    w_shift_d = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop1;
                    end else begin
                        w_bit_d = r_bit + 3'd1;
                    end
                end
            end
            StStop1: begin
                if (w_cnt_zero) begin
                    w_state_d = StStop2;
                    w_cnt_d   = BitReload;
                end
            end
            StStop2: begin
                if (w_cnt_zero) begin
                    if (r_slot == LastSlot) begin
                        // Enable is only sampled at frame end so frames are never truncated.
                        if (r_enable) begin
                            w_state_d = StBreak;
                            w_cnt_d   = BreakReload;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_state_d = StStart;
                        w_cnt_d   = BitReload;
                        w_slot_d  = r_slot + 10'd1;
                        w_shift_d = w_ram_rd;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign tx = r_tx;

endmodule
